hazard_unit: RTL and testbench

Producer side of the operand-forwarding path in the 5-stage pipeline. Sits beside the ID stage and owns the in-flight writeback tracker (ID/EX, EX/MEM, MEM/WB destination plus writeback control). Drives the write-address/writeback signals the forwarding logic consumes. Generates load-use and branch-operand stalls, the IF/ID flush for taken branches, and a saturating stall counter.

---
 rtl/hazard_unit_pkg.sv | 29 ++
 rtl/hazard_unit_wb_tracker.sv | 59 +++++
 rtl/hazard_unit.sv | 92 +++++++++
 tb/tb_hazard_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard/forwarding producer path:
// register-zero constant, writeback control bit positions and the tracker slot record.
package hazard_unit_pkg;

   localparam logic [4:0]  REG_ZERO    = 5'd0;
   localparam int unsigned WB_REGWRITE = 1;
   localparam int unsigned WB_MEMTOREG = 0;

   typedef struct packed {
      logic [4:0] waddr;
      logic       regwrite;
      logic       memtoreg;
      logic       memread;
   } slot_t;

   // True when an in-flight writer produces a register the ID instruction reads.
   function automatic logic src_hit(
      input logic [4:0] waddr,
      input logic       regwrite,
      input logic [4:0] rs,
      input logic       rs_use,
      input logic [4:0] rt,
      input logic       rt_use
   );
      return regwrite && (waddr != REG_ZERO) &&
             ((rs_use && (waddr == rs)) || (rt_use && (waddr == rt)));
   endfunction

endpackage

// File: rtl/hazard_unit_wb_tracker.sv
// Three-slot writeback tracker (ID/EX, EX/MEM, MEM/WB) shifting every cycle,
// with bubble insertion and register-zero write suppression at the ID entry.
module wb_tracker
   import hazard_unit_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       bubble_i,
   input  slot_t      id_slot_i,
   output logic [4:0] ex_waddr_o,
   output logic       ex_regwrite_o,
   output logic       ex_memread_o,
   output logic [4:0] mem_waddr_o,
   output logic [1:0] mem_wb_o,
   output logic [4:0] wb_waddr_o,
   output logic       wb_regwrite_o
);

   slot_t      ex_d, ex_q;
   logic [4:0] mem_waddr_q, wb_waddr_q;
   logic [1:0] mem_wb_q;
   logic       wb_regwrite_q;

   always_comb begin
      ex_d = id_slot_i;
      if (bubble_i) begin
         ex_d = '0;
      end else if (id_slot_i.waddr == REG_ZERO) begin
         ex_d.regwrite = 1'b0;
      end
   end

   // Past EX only the writeback controls survive; memread is meaningful in EX alone.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q          <= '0;
         mem_waddr_q   <= '0;
         mem_wb_q      <= '0;
         wb_waddr_q    <= '0;
         wb_regwrite_q <= 1'b0;
      end else begin
         ex_q                  <= ex_d;
         mem_waddr_q           <= ex_q.waddr;
         mem_wb_q[WB_REGWRITE] <= ex_q.regwrite;
         mem_wb_q[WB_MEMTOREG] <= ex_q.memtoreg;
         wb_waddr_q            <= mem_waddr_q;
         wb_regwrite_q         <= mem_wb_q[WB_REGWRITE];
      end
   end

   assign ex_waddr_o    = ex_q.waddr;
   assign ex_regwrite_o = ex_q.regwrite;
   assign ex_memread_o  = ex_q.memread;
   assign mem_waddr_o   = mem_waddr_q;
   assign mem_wb_o      = mem_wb_q;
   assign wb_waddr_o    = wb_waddr_q;
   assign wb_regwrite_o = wb_regwrite_q;

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard unit: load-use and branch-operand stalls, taken-branch IF/ID flush,
// saturating stall counter, and the in-flight writeback tracker feeding forwarding.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int unsigned DEPTH_CNT = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 id_valid_i,
   input  logic [4:0]           id_rs_i,
   input  logic [4:0]           id_rt_i,
   input  logic                 id_rs_use_i,
   input  logic                 id_rt_use_i,
   input  logic [4:0]           id_rd_i,
   input  logic [1:0]           id_wb_i,
   input  logic                 id_memread_i,
   input  logic                 id_branch_i,
   input  logic                 branch_taken_i,
   output logic                 pc_write_o,
   output logic                 ifid_write_o,
   output logic                 ifid_flush_o,
   output logic                 idex_bubble_o,
   output logic [4:0]           exmem_waddr_o,
   output logic [1:0]           exmem_wb_o,
   output logic [4:0]           memwb_waddr_o,
   output logic                 memwb_wb_o,
   output logic [DEPTH_CNT-1:0] stall_cnt_o
);

   slot_t                id_slot;
   logic [4:0]           ex_waddr;
   logic                 ex_regwrite, ex_memread;
   logic                 ex_hit, mem_hit, load_use, br_stall, stall, flush, bubble;
   logic                 flush_q;
   logic [DEPTH_CNT-1:0] cnt_d, cnt_q;

   always_comb begin
      ex_hit   = id_valid_i && src_hit(ex_waddr, ex_regwrite,
                                       id_rs_i, id_rs_use_i, id_rt_i, id_rt_use_i);
      mem_hit  = id_valid_i && src_hit(exmem_waddr_o, exmem_wb_o[WB_REGWRITE],
                                       id_rs_i, id_rs_use_i, id_rt_i, id_rt_use_i);
      load_use = ex_hit && ex_memread;
      // ID-stage compare needs the value now: any EX writer, or a load still in MEM.
      br_stall = id_branch_i && (ex_hit || (mem_hit && exmem_wb_o[WB_MEMTOREG]));
      stall    = load_use || br_stall;
      flush    = id_valid_i && id_branch_i && branch_taken_i && !stall;
      bubble   = !id_valid_i || stall || flush_q;

      id_slot          = '0;
      id_slot.waddr    = id_rd_i;
      id_slot.regwrite = id_wb_i[WB_REGWRITE];
      id_slot.memtoreg = id_wb_i[WB_MEMTOREG];
      id_slot.memread  = id_memread_i;

      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flush_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         flush_q <= flush;
         cnt_q   <= cnt_d;
      end
   end

   wb_tracker u_tracker (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .bubble_i      (bubble),
      .id_slot_i     (id_slot),
      .ex_waddr_o    (ex_waddr),
      .ex_regwrite_o (ex_regwrite),
      .ex_memread_o  (ex_memread),
      .mem_waddr_o   (exmem_waddr_o),
      .mem_wb_o      (exmem_wb_o),
      .wb_waddr_o    (memwb_waddr_o),
      .wb_regwrite_o (memwb_wb_o)
   );

   assign pc_write_o    = !stall;
   assign ifid_write_o  = !stall;
   assign idex_bubble_o = stall;
   assign ifid_flush_o  = flush;
   assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: hand-computed stall/flush/tracker expectations
// over load-use, branch, register-zero, reset and counter-saturation scenarios.
module tb_hazard_unit;

   localparam int unsigned CW = 6;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          id_valid_i, id_rs_use_i, id_rt_use_i, id_memread_i;
   logic          id_branch_i, branch_taken_i;
   logic [4:0]    id_rs_i, id_rt_i, id_rd_i;
   logic [1:0]    id_wb_i;
   logic          pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
   logic [4:0]    exmem_waddr_o, memwb_waddr_o;
   logic [1:0]    exmem_wb_o;
   logic          memwb_wb_o;
   logic [CW-1:0] stall_cnt_o;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   hazard_unit #(.DEPTH_CNT(CW)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .id_valid_i     (id_valid_i),
      .id_rs_i        (id_rs_i),
      .id_rt_i        (id_rt_i),
      .id_rs_use_i    (id_rs_use_i),
      .id_rt_use_i    (id_rt_use_i),
      .id_rd_i        (id_rd_i),
      .id_wb_i        (id_wb_i),
      .id_memread_i   (id_memread_i),
      .id_branch_i    (id_branch_i),
      .branch_taken_i (branch_taken_i),
      .pc_write_o     (pc_write_o),
      .ifid_write_o   (ifid_write_o),
      .ifid_flush_o   (ifid_flush_o),
      .idex_bubble_o  (idex_bubble_o),
      .exmem_waddr_o  (exmem_waddr_o),
      .exmem_wb_o     (exmem_wb_o),
      .memwb_waddr_o  (memwb_waddr_o),
      .memwb_wb_o     (memwb_wb_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Control bundle {pc_write, ifid_write, ifid_flush, idex_bubble}.
   task automatic chk_ctl(input string tag, input logic [3:0] exp);
      chk(tag, {28'd0, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o}, {28'd0, exp});
   endtask

   task automatic drv(input logic v, input logic [4:0] rs, input logic rsu,
                      input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                      input logic [1:0] wb, input logic mr, input logic br, input logic tk);
      id_valid_i     = v;
      id_rs_i        = rs;
      id_rs_use_i    = rsu;
      id_rt_i        = rt;
      id_rt_use_i    = rtu;
      id_rd_i        = rd;
      id_wb_i        = wb;
      id_memread_i   = mr;
      id_branch_i    = br;
      branch_taken_i = tk;
   endtask

   task automatic nop();
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic nxt();
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      nxt();
      rst_i = 1'b1;
      nop();
      nxt();
      rst_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      nop();

      // Reset state
      do_reset();
      #1;
      chk_ctl("rst_ctl", 4'b1100);
      chk("rst_exmem_waddr", {27'd0, exmem_waddr_o}, 32'd0);
      chk("rst_exmem_wb", {30'd0, exmem_wb_o}, 32'd0);
      chk("rst_memwb_waddr", {27'd0, memwb_waddr_o}, 32'd0);
      chk("rst_memwb_wb", {31'd0, memwb_wb_o}, 32'd0);
      chk("rst_cnt", {26'd0, stall_cnt_o}, 32'd0);

      // lw $2 ; add $3,$2,$4
      drv(1, 5'd1, 1, 5'd2, 0, 5'd2, 2'b11, 1, 0, 0); #1;
      chk_ctl("lu_c0_ctl", 4'b1100);
      nxt(); drv(1, 5'd2, 1, 5'd4, 1, 5'd3, 2'b10, 0, 0, 0); #1;
      chk_ctl("lu_c1_ctl", 4'b0001);
      chk("lu_c1_cnt", {26'd0, stall_cnt_o}, 32'd0);
      nxt(); #1;
      chk_ctl("lu_c2_ctl", 4'b1100);
      chk("lu_c2_exmem_waddr", {27'd0, exmem_waddr_o}, 32'd2);
      chk("lu_c2_exmem_wb", {30'd0, exmem_wb_o}, 32'd3);
      chk("lu_c2_cnt", {26'd0, stall_cnt_o}, 32'd1);
      nxt(); nop(); #1;
      chk("lu_c3_memwb_waddr", {27'd0, memwb_waddr_o}, 32'd2);
      chk("lu_c3_memwb_wb", {31'd0, memwb_wb_o}, 32'd1);
      chk("lu_c3_exmem_wb", {30'd0, exmem_wb_o}, 32'd0);
      nxt(); #1;
      chk("lu_c4_exmem_waddr", {27'd0, exmem_waddr_o}, 32'd3);
      chk("lu_c4_exmem_wb", {30'd0, exmem_wb_o}, 32'd2);

      // add $5,$1,$1 ; beq $5,$0  then  lw $5 ; beq $5,$0 (taken)
      do_reset();
      drv(1, 5'd1, 1, 5'd1, 1, 5'd5, 2'b10, 0, 0, 0); #1;
      chk_ctl("br_alu_c0_ctl", 4'b1100);
      nxt(); drv(1, 5'd5, 1, 5'd0, 1, 5'd0, 2'b00, 0, 1, 0); #1;
      chk_ctl("br_alu_c1_ctl", 4'b0001);
      nxt(); #1;
      chk_ctl("br_alu_c2_ctl", 4'b1100);
      nxt(); drv(1, 5'd1, 1, 5'd5, 0, 5'd5, 2'b11, 1, 0, 0); #1;
      chk_ctl("br_ld_c3_ctl", 4'b1100);
      nxt(); drv(1, 5'd5, 1, 5'd0, 1, 5'd0, 2'b00, 0, 1, 1); #1;
      chk_ctl("br_ld_c4_ctl", 4'b0001);
      nxt(); #1;
      chk_ctl("br_ld_c5_ctl", 4'b0001);
      nxt(); #1;
      chk_ctl("br_ld_c6_ctl", 4'b1110);
      chk("br_ld_c6_cnt", {26'd0, stall_cnt_o}, 32'd3);

      // Taken branch, no dependence: wrong-path add $7 must become a bubble
      do_reset();
      drv(1, 5'd1, 1, 5'd2, 1, 5'd0, 2'b00, 0, 1, 1); #1;
      chk_ctl("fl_c0_ctl", 4'b1110);
      nxt(); drv(1, 5'd1, 1, 5'd1, 1, 5'd7, 2'b10, 0, 0, 0); #1;
      chk_ctl("fl_c1_ctl", 4'b1100);
      nxt(); nop();
      nxt(); #1;
      chk("fl_c3_exmem_wb", {30'd0, exmem_wb_o}, 32'd0);
      chk("fl_c3_exmem_waddr", {27'd0, exmem_waddr_o}, 32'd0);

      // lw $0 ; add $3,$0,$4 : no stall, regwrite suppressed
      do_reset();
      drv(1, 5'd1, 1, 5'd0, 0, 5'd0, 2'b11, 1, 0, 0);
      nxt(); drv(1, 5'd0, 1, 5'd4, 1, 5'd3, 2'b10, 0, 0, 0); #1;
      chk_ctl("z_c1_ctl", 4'b1100);
      nxt(); nop(); #1;
      chk("z_c2_regwrite", {31'd0, exmem_wb_o[1]}, 32'd0);
      chk("z_c2_cnt", {26'd0, stall_cnt_o}, 32'd0);

      // lw $2 ; lw $3,0($2) ; add $4,$3,$3 : each dependent stalls once
      do_reset();
      drv(1, 5'd1, 1, 5'd2, 0, 5'd2, 2'b11, 1, 0, 0);
      nxt(); drv(1, 5'd2, 1, 5'd3, 0, 5'd3, 2'b11, 1, 0, 0); #1;
      chk_ctl("b2b_c1_ctl", 4'b0001);
      nxt(); #1;
      chk_ctl("b2b_c2_ctl", 4'b1100);
      nxt(); drv(1, 5'd3, 1, 5'd3, 1, 5'd4, 2'b10, 0, 0, 0); #1;
      chk_ctl("b2b_c3_ctl", 4'b0001);
      nxt(); #1;
      chk_ctl("b2b_c4_ctl", 4'b1100);
      chk("b2b_c4_cnt", {26'd0, stall_cnt_o}, 32'd2);

      // Reset asserted during a load-use stall
      do_reset();
      drv(1, 5'd1, 1, 5'd2, 0, 5'd2, 2'b11, 1, 0, 0);
      nxt(); drv(1, 5'd2, 1, 5'd4, 1, 5'd3, 2'b10, 0, 0, 0); rst_i = 1'b1; #1;
      chk_ctl("rms_c1_ctl", 4'b0001);
      nxt(); rst_i = 1'b0; #1;
      chk_ctl("rms_c2_ctl", 4'b1100);
      chk("rms_c2_cnt", {26'd0, stall_cnt_o}, 32'd0);
      chk("rms_c2_exmem_wb", {30'd0, exmem_wb_o}, 32'd0);
      chk("rms_c2_memwb_wb", {31'd0, memwb_wb_o}, 32'd0);

      // Reset on a flush cycle clears the flush history
      nxt(); drv(1, 5'd1, 1, 5'd2, 1, 5'd0, 2'b00, 0, 1, 1); rst_i = 1'b1; #1;
      chk_ctl("rfl_c0_ctl", 4'b1110);
      nxt(); rst_i = 1'b0; drv(1, 5'd1, 1, 5'd1, 1, 5'd7, 2'b10, 0, 0, 0);
      nxt(); nop();
      nxt(); #1;
      chk("rfl_c3_exmem_waddr", {27'd0, exmem_waddr_o}, 32'd7);
      chk("rfl_c3_exmem_wb", {30'd0, exmem_wb_o}, 32'd2);

      // Repeating load+dependent-branch pattern: 2 stalls every 3 cycles
      do_reset();
      drv(1, 5'd5, 1, 5'd0, 0, 5'd5, 2'b11, 1, 1, 0);
      repeat (30) nxt();
      #1;
      chk("sat_mid_cnt", {26'd0, stall_cnt_o}, 32'd20);
      repeat (90) nxt();
      #1;
      chk("sat_end_cnt", {26'd0, stall_cnt_o}, 32'd63);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
